// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg
//   Shared definitions for the receive word FIFO:
//   - default parameter values for rx_word_fifo
//   - read FSM state encoding (IDLE, WAIT, DELIVER)
//   - byte-lane mapping helper used by the word assembler
package rx_fifo_pkg;

  localparam int unsigned DEF_WORD_BYTES = 4;
  localparam int unsigned DEF_DEPTH_LOG2 = 10;
  localparam bit          DEF_MSB_FIRST  = 1'b1;

  // Lane counter width; covers the full 1..8 bytes-per-word range.
  localparam int unsigned LANE_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2
  } rd_state_t;

  // Map the running byte count to the physical byte lane it fills.
  function automatic logic [LANE_W-1:0] lane_slot(
    input logic [LANE_W-1:0] lane,
    input int unsigned       word_bytes,
    input bit                msb_first
  );
    if (msb_first) return LANE_W'(word_bytes - 1) - lane;
    else           return lane;
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem
//   Simple dual-port RAM: synchronous write port, registered read port.
//   The array itself is never reset so it can map onto block RAM; only
//   the read output register is cleared by reset. The read register holds
//   its value while rd_en is low.
//
// Ports
//   CLK      in   clock
//   reset    in   asynchronous active-low clear of the read register
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; loads rd_data from mem[rd_addr]
//   rd_addr  in   read address
//   rd_data  out  registered read data
module rx_fifo_mem #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_word_fifo.sv
// rx_word_fifo
//   Packs received UART bytes into WORD_BYTES-wide words, buffers them in
//   a 2**DEPTH_LOG2 entry FIFO and hands one word out per rising edge of
//   rd_req. Words that complete while the FIFO is full are dropped and
//   flagged on the sticky overflow output.
//
// Ports
//   CLK         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   data        in   received byte
//   valid       in   one-cycle strobe qualifying data
//   rd_req      in   read request level; rising edge requests one word
//   flush       in   synchronous clear of FIFO, assembler and read FSM
//   input_data  out  last delivered word, held between deliveries
//   ready       out  one-cycle pulse marking a new input_data value
//   count       out  number of stored words (registered)
//   empty       out  count == 0 (registered)
//   overflow    out  sticky: a completed word was dropped on a full FIFO
module rx_word_fifo
  import rx_fifo_pkg::*;
#(
  parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter bit          MSB_FIRST  = DEF_MSB_FIRST
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [7:0]              data,
  input  logic                    valid,
  input  logic                    rd_req,
  input  logic                    flush,
  output logic [8*WORD_BYTES-1:0] input_data,
  output logic                    ready,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    empty,
  output logic                    overflow
);

  localparam int unsigned       WORD_W     = 8 * WORD_BYTES;
  localparam int unsigned       DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(WORD_BYTES - 1);

  // Assembler
  logic [LANE_W-1:0]     lane_cnt;
  logic [LANE_W-1:0]     slot;
  logic [WORD_W-1:0]     asm_word;
  logic [WORD_W-1:0]     asm_next;
  logic                  push_req;

  // FIFO bookkeeping and read side
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  push_ok;
  logic                  wr_en;
  logic                  pop;
  logic                  rd_req_q;
  logic                  rd_edge;
  rd_state_t             state;

  // ---------------------------------------------------------------------
  // Word assembler
  // ---------------------------------------------------------------------
  always_comb begin
    slot     = lane_slot(lane_cnt, WORD_BYTES, MSB_FIRST);
    asm_next = asm_word;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (slot == LANE_W'(i)) asm_next[8*i +: 8] = data;
    end
  end

  // The finished word stays in asm_word during the push cycle; a byte of
  // the next word accepted in that same cycle only lands at the push edge,
  // so the RAM write still sees the complete previous word.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      lane_cnt <= '0;
      asm_word <= '0;
      push_req <= 1'b0;
    end else if (flush) begin
      lane_cnt <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= valid && (lane_cnt == LAST_LANE);
      if (valid) begin
        asm_word <= asm_next;
        lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Push / pop decisions
  // ---------------------------------------------------------------------
  assign rd_edge = rd_req && !rd_req_q;
  assign push_ok = push_req && (count != FULL_COUNT);
  assign wr_en   = push_ok && !flush;
  assign pop     = !flush && !empty &&
                   (((state == IDLE) && rd_edge) || (state == WAIT));

  always_comb begin
    count_next = count;
    if (push_ok && !pop)      count_next = count + 1'b1;
    else if (pop && !push_ok) count_next = count - 1'b1;
  end

  // ---------------------------------------------------------------------
  // Pointers, status flags and read FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      rd_req_q <= 1'b0;
      state    <= IDLE;
      ready    <= 1'b0;
    end else begin
      rd_req_q <= rd_req;
      if (flush) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        empty    <= 1'b1;
        overflow <= 1'b0;
        state    <= IDLE;
        ready    <= 1'b0;
      end else begin
        if (push_ok)                          head     <= head + 1'b1;
        if (pop)                              tail     <= tail + 1'b1;
        if (push_req && (count == FULL_COUNT)) overflow <= 1'b1;
        count <= count_next;
        empty <= (count_next == '0);

        case (state)
          IDLE: begin
            ready <= 1'b0;
            if (rd_edge) begin
              if (!empty) begin
                state <= DELIVER;
                ready <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end
          WAIT: begin
            ready <= 1'b0;
            if (!empty) begin
              state <= DELIVER;
              ready <= 1'b1;
            end
          end
          DELIVER: begin
            ready <= 1'b0;
            state <= IDLE;
          end
          default: begin
            ready <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Storage; the registered read port doubles as the input_data holding
  // register, so it only reloads on a pop and keeps its value on flush.
  // ---------------------------------------------------------------------
  rx_fifo_mem #(
    .WIDTH  (WORD_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .CLK     (CLK),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (head),
    .wr_data (asm_word),
    .rd_en   (pop),
    .rd_addr (tail),
    .rd_data (input_data)
  );

endmodule

// File: doc/rx_word_fifo.md
RX_WORD_FIFO -- requirements
Module: rx_word_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, using the port names CLK and reset.
REQ-002 Parameter WORD_BYTES, default 4: bytes per assembled word, legal range 1..8.
REQ-003 Parameter DEPTH_LOG2, default 10: the FIFO holds 2**DEPTH_LOG2 words.
REQ-004 Parameter MSB_FIRST, default 1: 1 = first received byte lands in the top byte lane; 0 = first byte lands in lane 0.
REQ-005 CLK  in  1  system clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-007 data  in  8  received UART byte.
REQ-008 valid  in  1  one-cycle strobe qualifying data.
REQ-009 rd_req  in  1  read request level; only its rising edge has effect.
REQ-010 flush  in  1  synchronous clear of the FIFO and the assembler.
REQ-011 input_data  out  8*WORD_BYTES  last delivered word; held between deliveries.
REQ-012 ready  out  1  one-cycle pulse marking a new input_data value.
REQ-013 count  out  DEPTH_LOG2+1  number of words stored.
REQ-014 empty  out  1  high when count==0.
REQ-015 overflow  out  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-016 Assembler: lane counter 0..WORD_BYTES-1; each valid writes data into the current lane and advances the counter.
- The lane order follows MSB_FIRST.
- The counter wraps to 0 after lane WORD_BYTES-1.
REQ-017 The completed word SHALL be written to mem[head] on the cycle after its last byte is accepted, and head SHALL then increment modulo 2**DEPTH_LOG2.
REQ-018 A completed word arriving with count==2**DEPTH_LOG2 SHALL be discarded and SHALL set overflow; head and count SHALL stay unchanged.
REQ-019 A valid strobe SHALL be accepted on every cycle, including the cycle in which the previous word is pushed; there are no stall cycles.
REQ-020 rd_req edge = rd_req high now and low on the previous cycle.
REQ-021 Read FSM has three states:
- IDLE: on an edge with !empty, pop mem[tail] and go to DELIVER; on an edge with empty, go to WAIT.
- WAIT: on the first cycle with !empty, pop and go to DELIVER.
- DELIVER: drive input_data with the popped word, pulse ready for one cycle, return to IDLE.
REQ-022 Pop = tail increments modulo the depth and count decrements.
- ready SHALL assert exactly one cycle after the pop cycle.
- Latency from the rd_req edge to ready SHALL be 1 cycle when the FIFO is non-empty.
REQ-023 rd_req edges arriving while the FSM is in WAIT or DELIVER SHALL be ignored; they are not queued.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged and SHALL operate on the correct entries.
REQ-025 A push into an empty FIFO while in WAIT SHALL produce a pop on the cycle after the push and ready on the cycle after that.
REQ-026 Flush SHALL, at the next edge:
- zero head, tail, count and the lane counter;
- clear overflow;
- return the FSM to IDLE and force ready low.
- input_data SHALL retain its value.
- Flush SHALL take priority over a simultaneous valid, push or rd_req edge.
REQ-027 count and empty SHALL be registered outputs that reflect the state after the last clock edge.

Reset
REQ-028 While reset is 0, every output SHALL be cleared regardless of CLK:
- input_data=0, ready=0, count=0, empty=1, overflow=0.
- The FSM SHALL be in IDLE, with head, tail, lane counter and rd_req history all 0.
REQ-029 Memory contents SHALL NOT be reset, so that the array infers block RAM; unread entries are don't-care.
REQ-030 A reset asserted mid-word or mid-read SHALL discard the partial word and any pending request; no ready pulse SHALL follow the release of reset.

Structure
REQ-031 Package rx_fifo_pkg SHALL hold:
- the FSM state enum typedef (IDLE, WAIT, DELIVER);
- the default parameter constants.
REQ-032 Storage SHALL be a sub-module rx_fifo_mem: a simple dual-port RAM with a synchronous write and a registered read, parameterised by width and depth.

Verification
REQ-033 Default parameters, bytes 0x12 0x34 0x56 0x78, then an rd_req edge -> input_data=0x12345678, ready high for 1 cycle, count 1->0.
REQ-034 MSB_FIRST=0, same bytes -> input_data=0x78563412.
REQ-035 rd_req edge while empty, then bytes 0xDE 0xAD 0xBE 0xEF -> the FSM sits in WAIT; ready arrives 2 cycles after the push with input_data=0xDEADBEEF.
REQ-036 DEPTH_LOG2=2, push 5 words (1..5) -> count=4, overflow=1; four reads return 1,2,3,4, then empty=1.
REQ-037 Flush asserted after 2 bytes plus 3 stored words -> count=0, overflow=0; the next 4 bytes 0xAA 0xBB 0xCC 0xDD read back as 0xAABBCCDD.
REQ-038 reset driven low between bytes 2 and 3, then released -> all outputs at reset values, no ready pulse; a fresh 4-byte word reads back intact.
